// File: rtl/picorv_mem_arbiter.sv
// Two-port memory arbiter in front of a single downstream (AHB adapter) request port.
// Round-robin or fixed-priority grant, registered downstream request, optional wait timeout.
module picorv_mem_arbiter #(
    parameter int unsigned RR_MODE        = 1,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    localparam logic [15:0] ToLast =
        (TIMEOUT_CYCLES == 0) ? 16'hFFFF : 16'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic        s_valid_q, s_valid_d;
    logic        s_instr_q, s_instr_d;
    logic [31:0] s_addr_q, s_addr_d;
    logic [31:0] s_wdata_q, s_wdata_d;
    logic [3:0]  s_wstrb_q, s_wstrb_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [15:0] wait_q, wait_d;
    logic        m0_ready_q, m0_ready_d;
    logic        m1_ready_q, m1_ready_d;
    logic [31:0] m0_rdata_q, m0_rdata_d;
    logic [31:0] m1_rdata_q, m1_rdata_d;
    logic        timeout_q, timeout_d;

    logic any_req;
    logic winner;
    logic timeout_hit;

    assign any_req     = m0_valid | m1_valid;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_q == ToLast);

    // Tie goes to the port not served last in round-robin mode, else to port 0.
    always_comb begin
        winner = 1'b0;
        if (m0_valid && m1_valid) begin
            winner = (RR_MODE != 0) ? ~last_grant_q : 1'b0;
        end else begin
            winner = m1_valid;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            s_valid_q    <= 1'b0;
            s_instr_q    <= 1'b0;
            s_addr_q     <= 32'h0;
            s_wdata_q    <= 32'h0;
            s_wstrb_q    <= 4'h0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            wait_q       <= 16'h0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
            m0_rdata_q   <= 32'h0;
            m1_rdata_q   <= 32'h0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_valid_q    <= s_valid_d;
            s_instr_q    <= s_instr_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            s_wstrb_q    <= s_wstrb_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            wait_q       <= wait_d;
            m0_ready_q   <= m0_ready_d;
            m1_ready_q   <= m1_ready_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
            timeout_q    <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (any_req) state_d = StBusy;
            StBusy: if (s_ready || timeout_hit) state_d = StResp;
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        s_valid_d    = s_valid_q;
        s_instr_d    = s_instr_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        s_wstrb_d    = s_wstrb_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        wait_d       = wait_q;
        m0_ready_d   = 1'b0;
        m1_ready_d   = 1'b0;
        m0_rdata_d   = 32'h0;
        m1_rdata_d   = 32'h0;
        timeout_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    s_valid_d    = 1'b1;
                    s_instr_d    = winner ? m1_instr : m0_instr;
                    s_addr_d     = winner ? m1_addr  : m0_addr;
                    s_wdata_d    = winner ? m1_wdata : m0_wdata;
                    s_wstrb_d    = winner ? m1_wstrb : m0_wstrb;
                    grant_d      = winner;
                    last_grant_d = winner;
                    wait_d       = 16'h0;
                end
            end
            StBusy: begin
                // A completion on the expiry cycle wins over the timeout.
                if (s_ready || timeout_hit) begin
                    s_valid_d  = 1'b0;
                    m0_ready_d = ~grant_q;
                    m1_ready_d = grant_q;
                    timeout_d  = ~s_ready;
                    if (s_ready) begin
                        m0_rdata_d = grant_q ? 32'h0 : s_rdata;
                        m1_rdata_d = grant_q ? s_rdata : 32'h0;
                    end
                end else begin
                    wait_d = wait_q + 16'h1;
                end
            end
            StResp: begin
            end
            default: begin
            end
        endcase
    end

    assign s_valid     = s_valid_q;
    assign s_instr     = s_instr_q;
    assign s_addr      = s_addr_q;
    assign s_wdata     = s_wdata_q;
    assign s_wstrb     = s_wstrb_q;
    assign grant       = grant_q;
    assign timeout_err = timeout_q;
    assign m0_ready    = m0_ready_q;
    assign m1_ready    = m1_ready_q;
    assign m0_rdata    = m0_rdata_q;
    assign m1_rdata    = m1_rdata_q;

endmodule
